// File: rtl/row_packer_pkg.sv
// Shared derived constants and parameter checks for the row packer and its row FIFO.
package row_packer_pkg;

    localparam int ROWS_OUT_W = 16;

    function automatic int elems_per_beat(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    function automatic int stage_elems(input int row_elems, input int epb);
        return row_elems + epb - 1;
    endfunction

    function automatic int cnt_width(input int stage);
        return $clog2(stage + 1);
    endfunction

    function automatic int row_width(input int data_width, input int row_elems);
        return data_width * row_elems;
    endfunction

    function automatic bit params_ok(input int data_width, input int row_elems,
                                     input int bus_width, input int fifo_depth);
        return (data_width > 0) && (row_elems > 0) && (bus_width >= data_width) &&
               ((bus_width % data_width) == 0) && (fifo_depth >= 1);
    endfunction

endpackage

// File: rtl/row_fifo.sv
// First-word-fall-through row FIFO; a push while full is taken only when a pop frees a slot
// on the same edge. Synchronous clear whenever rstn or enable is low.
module row_fifo
    import row_packer_pkg::*;
#(
    parameter int WIDTH = 25,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == {CNT_W{1'b0}});
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign dout      = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d = mem_q;
        mem_d[wr_ptr_q] = do_push_s ? din : mem_q[wr_ptr_q];
        wr_ptr_d = do_push_s ? ((wr_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1))
                             : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? ((rd_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1))
                             : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end

    // State registers with synchronous clear
    always_ff @(posedge clk) begin
        if (!rstn || !enable) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/row_packer.sv
// Packs dense AXI-Stream beats into ROW_ELEMS-element kernel rows (oldest element in the MSBs),
// zero-pads the final partial row of a frame, and buffers finished rows in a FWFT FIFO.
module row_packer
    import row_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_ELEMS  = 3,
    parameter int BUS_WIDTH  = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            enable,
    input  logic [BUS_WIDTH-1:0]            s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [DATA_WIDTH*ROW_ELEMS-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [15:0]                     rows_out
);

    localparam int EPB   = elems_per_beat(BUS_WIDTH, DATA_WIDTH);
    localparam int STAGE = stage_elems(ROW_ELEMS, EPB);
    localparam int CNT_W = cnt_width(STAGE);
    localparam int ROW_W = row_width(DATA_WIDTH, ROW_ELEMS);

    localparam logic [CNT_W-1:0] ROW_CNT = CNT_W'(ROW_ELEMS);
    localparam logic [CNT_W-1:0] EPB_CNT = CNT_W'(EPB);
    localparam logic [CNT_W:0]   ROW_X   = (CNT_W + 1)'(ROW_ELEMS);
    localparam logic [CNT_W:0]   ROW2_X  = (CNT_W + 1)'(2 * ROW_ELEMS);

    if (!params_ok(DATA_WIDTH, ROW_ELEMS, BUS_WIDTH, FIFO_DEPTH)) begin : g_param_check
        $error("row_packer: BUS_WIDTH must be a multiple of DATA_WIDTH and FIFO_DEPTH >= 1");
    end

    logic [DATA_WIDTH-1:0] stage_q   [STAGE];
    logic [DATA_WIDTH-1:0] stage_d   [STAGE];
    logic [DATA_WIDTH-1:0] shifted_s [STAGE];
    logic [DATA_WIDTH-1:0] beat_s    [EPB];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_pending_q, last_pending_d;
    logic [15:0]           rows_out_q, rows_out_d;

    logic                  active_s;
    logic                  accept_s;
    logic                  emit_s;
    logic                  pop_s;
    logic                  row_last_s;
    logic [CNT_W:0]        cnt_x_s;
    logic [CNT_W-1:0]      take_s;
    logic [CNT_W-1:0]      base_s;
    logic [ROW_W-1:0]      row_s;
    logic [ROW_W:0]        fifo_dout_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    assign active_s   = enable & rstn;
    assign cnt_x_s    = {1'b0, cnt_q};

    // Input readiness depends only on registered state, never on m_axis_tready.
    assign s_axis_tready = active_s & ~last_pending_q &
                           ((cnt_x_s < ROW_X) | ((cnt_x_s < ROW2_X) & ~fifo_full_s));
    assign accept_s   = s_axis_tvalid & s_axis_tready;

    assign m_axis_tvalid = active_s & ~fifo_empty_s;
    assign pop_s         = m_axis_tvalid & m_axis_tready;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_dout_s[ROW_W-1:0] : {ROW_W{1'b0}};
    assign m_axis_tlast  = m_axis_tvalid & fifo_dout_s[ROW_W];
    assign rows_out      = rows_out_q;

    assign emit_s     = ((cnt_x_s >= ROW_X) | (last_pending_q & (cnt_q != {CNT_W{1'b0}}))) &
                        (~fifo_full_s | pop_s);
    assign take_s     = emit_s ? ((cnt_x_s >= ROW_X) ? ROW_CNT : cnt_q) : {CNT_W{1'b0}};
    assign base_s     = cnt_q - take_s;
    assign row_last_s = last_pending_q & (cnt_x_s <= ROW_X);

    // Oldest ROW_ELEMS elements, first element in the MSBs, zero beyond cnt
    always_comb begin
        row_s = {ROW_W{1'b0}};
        for (int i = 0; i < ROW_ELEMS; i++) begin
            row_s[(ROW_ELEMS-1-i)*DATA_WIDTH +: DATA_WIDTH] =
                (CNT_W'(i) < cnt_q) ? stage_q[i] : {DATA_WIDTH{1'b0}};
        end
    end

    // Split the input beat into elements, element 0 from the LSBs
    always_comb begin
        for (int j = 0; j < EPB; j++) begin
            beat_s[j] = s_axis_tdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Drop the emitted elements from the head of the staging register
    always_comb begin
        for (int i = 0; i < STAGE; i++) begin
            shifted_s[i] = stage_q[i];
            for (int k = 1; k <= ROW_ELEMS; k++) begin
                shifted_s[i] = (take_s == CNT_W'(k))
                    ? ((i + k < STAGE) ? stage_q[(i + k < STAGE) ? (i + k) : 0] : {DATA_WIDTH{1'b0}})
                    : shifted_s[i];
            end
        end
    end

    // Append an accepted beat behind the surviving elements
    always_comb begin
        for (int p = 0; p < STAGE; p++) begin
            stage_d[p] = shifted_s[p];
            for (int j = 0; j < EPB; j++) begin
                stage_d[p] = (accept_s && (p >= j) && (base_s == CNT_W'(p - j)))
                             ? beat_s[j] : stage_d[p];
            end
        end
    end

    // Element count, frame-end tracking and handed-off row counter
    always_comb begin
        cnt_d          = base_s + (accept_s ? EPB_CNT : {CNT_W{1'b0}});
        last_pending_d = (last_pending_q & ~(emit_s & row_last_s)) | (accept_s & s_axis_tlast);
        rows_out_d     = rows_out_q + (pop_s ? 16'd1 : 16'd0);
    end

    // Staging state with synchronous clear on rstn or enable low
    always_ff @(posedge clk) begin
        if (!rstn || !enable) begin
            cnt_q          <= {CNT_W{1'b0}};
            last_pending_q <= 1'b0;
            rows_out_q     <= 16'd0;
            for (int i = 0; i < STAGE; i++) begin
                stage_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            cnt_q          <= cnt_d;
            last_pending_q <= last_pending_d;
            rows_out_q     <= rows_out_d;
            stage_q        <= stage_d;
        end
    end

    row_fifo #(
        .WIDTH (ROW_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .enable (enable),
        .push   (emit_s),
        .din    ({row_last_s, row_s}),
        .pop    (pop_s),
        .dout   (fifo_dout_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

endmodule

// File: doc/row_packer.md
Name: row_packer

Overview:
- Parametrised successor to the single-row accumulator in the map-inflation datapath.
- Packs densely-packed AXI-Stream bus beats into kernel rows of ROW_ELEMS elements. Elements may straddle beats, and no padding is wasted per row.
- Buffers up to FIFO_DEPTH completed rows so input keeps flowing while the consumer stalls.
- Supports frame termination via tlast, with zero-padded flush of a partial final row.
- Sits between the DMA input stream and the convolution/inflation kernel.

Parameters:
- DATA_WIDTH, 8, bits per element.
- ROW_ELEMS, 3, elements per output row (kernel size).
- BUS_WIDTH, 32, input beat width; must be an integer multiple of DATA_WIDTH (elaboration-time assertion).
- FIFO_DEPTH, 2, completed rows buffered; must be >= 1.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- enable  in  1  low = synchronous clear, same effect as reset (held low during weight loading)
- s_axis_tdata  in  BUS_WIDTH  E = BUS_WIDTH/DATA_WIDTH elements; element 0 in the LSBs
- s_axis_tvalid  in  1  input beat valid
- s_axis_tlast  in  1  last beat of frame
- s_axis_tready  out  1  beat accepted when valid & ready
- m_axis_tdata  out  DATA_WIDTH*ROW_ELEMS  row; first-received element in the MSBs
- m_axis_tvalid  out  1  row valid
- m_axis_tlast  out  1  last row of frame
- m_axis_tready  in  1  consumer ready
- rows_out  out  16  count of rows handed off on m_axis, wrapping modulo 2^16

Behaviour:
- Reset and clock: rstn is synchronous, active-low; clock is clk.
- Reset / enable low (any cycle, including mid-frame or mid-row):
  - staging count = 0, last_pending = 0, FIFO emptied, rows_out = 0.
  - s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
  - Any partial row is discarded.
- Staging register:
  - Capacity ROW_ELEMS+E-1 elements, with element count cnt.
  - An accepted beat appends its E elements in order, element 0 first.
- Emit condition: a row moves from staging to the FIFO on a clock edge when (cnt >= ROW_ELEMS or (last_pending and cnt > 0)) and the FIFO is not full.
  - An emitted row takes the oldest ROW_ELEMS elements.
  - If cnt < ROW_ELEMS (flush case), the missing trailing elements are zero.
  - cnt decreases by min(cnt, ROW_ELEMS).
- Row tlast: a row is tagged tlast iff last_pending and its emission leaves cnt = 0. last_pending then clears on that edge.
- s_axis_tready:
  - Registered-state function only; no combinational path from m_axis_tready.
  - Equals enable & rstn & !last_pending & (cnt < ROW_ELEMS or (cnt < 2*ROW_ELEMS and FIFO not full)).
- Same-cycle accept and emit: both occur on the same edge. New cnt = cnt - ROW_ELEMS + E. Capacity is never exceeded.
- Accepting a beat with s_axis_tlast = 1 sets last_pending. Input stalls until the frame's final row enters the FIFO.
- Output stage:
  - FIFO is first-word-fall-through, and m_axis_* are driven from the head entry.
  - Pop occurs on m_axis_tvalid & m_axis_tready.
  - Push and pop in the same cycle are allowed when full: the FIFO stays full and order is preserved.
  - When empty, push then pop happens with one cycle of latency; a row is never visible in the cycle it is pushed.
  - m_axis_tdata and m_axis_tlast hold stable while valid & !ready.
- Latency: beat accepted at edge t → row pushed at edge t+1 → m_axis_tvalid high after edge t+1, i.e. 2 cycles from s-handshake to m-valid with no backpressure.
- Throughput:
  - When E >= ROW_ELEMS, input stalls whenever cnt >= 2*ROW_ELEMS.
  - Otherwise, one beat per cycle is sustained as long as the consumer is always ready.
- rows_out increments on every m-side handshake.

Decomposition:
- Package row_packer_pkg:
  - Derived constants as functions of parameters: ELEMS_PER_BEAT, STAGE_ELEMS = ROW_ELEMS+ELEMS_PER_BEAT-1, CNT_W = $clog2(STAGE_ELEMS+1), ROW_W.
  - Parameter-check function used by the elaboration assertions.
- One sub-module: row_fifo.
  - Synchronous FWFT FIFO, width ROW_W+1 (row data + tlast), depth FIFO_DEPTH.
  - Provides full/empty flags.
  - Same synchronous-clear behaviour on rstn/enable.
- Staging, emit and tready logic live in row_packer.

Test Plan:
- Config DATA_WIDTH=8, ROW_ELEMS=3, BUS_WIDTH=32, consumer always ready. Send beats 0x03020100, 0x07060504, 0x0B0A0908 (last on the third) → rows 0x000102, 0x030405, 0x060708, 0x090A0B. tlast on the fourth row only; rows_out = 4. First tvalid 2 cycles after the first accept.
- Same config, single beat 0x03020100 with tlast → rows 0x000102, then 0x030000 with tlast (zero-padded flush). tready low until the flush row is pushed.
- Backpressure: m_axis_tready = 0 for 20 cycles while the source streams → tready drops once the FIFO is full and cnt >= 3. Held m_axis_tdata is stable. After release, all rows arrive in order with no loss or duplication.
- Mid-row reset: accept 0x03020100, then pulse enable low for 1 cycle → tvalid = 0, cnt cleared. The next beats 0x07060504, 0x0B0A0908 yield rows 0x040506, 0x07080 9 → 0x070809, with leftover 0x0A0B pending.
- Wide-row config ROW_ELEMS=9, BUS_WIDTH=32: 3 beats (12 elements) with tlast on the third → one full row, then a row of 3 elements + 6 zero elements with tlast.
- Simultaneous push/pop with the FIFO full (FIFO_DEPTH=2): the consumer pops while the stager pushes → occupancy stays 2 and order is preserved. rows_out wraps from 0xFFFF to 0x0000 (force the count or run long).
